// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the pc_sequencer control slice.
//   - state_t   : FSM state encoding (FETCH=0 .. ERROR=6)
//   - OP_*      : 6-bit primary opcodes recognised by the decoder
//   - ALU_*     : ALUOp codes presented to the ALU control
//   - is_exec_op: true for opcodes that need an EXEC stage
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_exec_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/pc_sequencer_wait_timer.sv
// seq_wait_timer: counts cycles a request has been waiting for its ack.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  restart the count (takes priority over inc)
//   inc     in  request pending without ack this cycle
//   expired out this is the WAIT_MAX-th unacknowledged cycle
module seq_wait_timer #(
  parameter int WAIT_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // The count only needs to reach WAIT_MAX-1; expiry is detected on the
  // cycle that would bring it to WAIT_MAX.
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] cnt_q;

  assign expired = inc && (cnt_q == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM around ProgramCounter.
// Fetches one instruction per imem handshake, decodes the latched opcode and
// drives PC, register file, ALU and data-memory controls. Counts retired
// instructions and traps to ERROR when a handshake waits too long.
// Ports:
//   CLK, MasterReset        clock, synchronous active-high reset
//   opcode                  instr[31:26], captured on the IRWrite cycle
//   imem_ack, dmem_ack      memory handshake acknowledges
//   imem_req, IRWrite       fetch request, instruction register load
//   dmem_req, dmem_we       data memory request / write
//   PCWrite, nPC_Sel        PC advance strobe and branch select
//   RegWrite, RegDst, ALUSrc, MemToReg, ALUOp   datapath controls
//   halted, error           in HALT / ERROR state
//   retired                 retired-instruction count (wraps)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             MasterReset,
  input  logic [5:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             PCWrite,
  output logic             nPC_Sel,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic [1:0]       ALUOp,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  state_t             state_q, state_d;
  logic [5:0]         op_q;
  logic [CNT_W-1:0]   retired_q;
  logic               wait_inc, wait_clr, wait_expired;

  // Waiting is judged from registered state and the raw acks so the timer
  // output does not depend on the next-state decode.
  assign wait_inc = !MasterReset &&
                    (((state_q == S_FETCH) && !imem_ack) ||
                     ((state_q == S_MEM)   && !dmem_ack));
  // Any state change restarts the count, so FETCH and MEM are always
  // entered with a zero count.
  assign wait_clr = (state_d != state_q);

  seq_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (CLK),
    .rst     (MasterReset),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    PCWrite  = 1'b0;
    nPC_Sel  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemToReg = 1'b0;
    ALUOp    = ALU_ADD;
    halted   = 1'b0;
    error    = 1'b0;

    if (MasterReset) begin
      // Outputs stay at their zero defaults; any ack now is ignored.
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            IRWrite = 1'b1;
            state_d = S_DECODE;
          end else if (wait_expired) begin
            state_d = S_ERROR;
          end
        end

        S_DECODE: begin
          if (op_q == OP_HALT) begin
            state_d = S_HALT;
          end else if (is_exec_op(op_q)) begin
            state_d = S_EXEC;
          end else begin
            // Unknown opcode retires as a NOP.
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end
        end

        S_EXEC: begin
          unique case (op_q)
            OP_RTYPE: begin
              ALUOp   = ALU_FUNCT;
              RegDst  = 1'b1;
              state_d = S_WB;
            end
            OP_ADDI: begin
              ALUSrc  = 1'b1;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              ALUSrc  = 1'b1;
              state_d = S_MEM;
            end
            OP_BEQ: begin
              ALUOp   = ALU_SUB;
              nPC_Sel = 1'b1;
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end
            default: state_d = S_ERROR;
          endcase
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (op_q == OP_SW);
          ALUSrc   = 1'b1;
          if (dmem_ack) begin
            if (op_q == OP_SW) begin
              PCWrite = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_expired) begin
            state_d = S_ERROR;
          end
        end

        S_WB: begin
          RegWrite = 1'b1;
          MemToReg = (op_q == OP_LW);
          RegDst   = (op_q == OP_RTYPE);
          ALUSrc   = (op_q == OP_ADDI) || (op_q == OP_LW);
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end

        S_HALT:  halted = 1'b1;
        S_ERROR: error  = 1'b1;
        default: state_d = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (IRWrite) op_q <= opcode;
      if (PCWrite) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = MasterReset ? '0 : retired_q;

endmodule
